regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the pipelined MIPS core, sitting between decode (read/allocate) and write-back (write). It generalises the fixed 32x32, two-read-port register file with hardwired zero register, a per-register pending-write scoreboard for hazard detection, and a sequential post-reset clear sequencer. Reads are combinational; writes, allocation and clearing are clocked.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers, power of two, at least 2
- ADDR_W, 5, address width, equal to log2(NREGS)
- NRD, 2, number of read ports, 1 to 4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRD*ADDR_W  read addresses; port i in bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, same packing
- rd_pending  out  NRD  port i's register has an outstanding write
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back value
- alloc_en  in  1  decode issues an instruction that will write alloc_addr
- alloc_addr  in  ADDR_W  destination being allocated
- busy  out  1  clear sequence in progress; all writes and allocations ignored

Reset: rst, synchronous, active-high; clock: clk.

## Operation
- States: CLEAR, READY. A rising edge with rst=1 sets state=CLEAR, clr_ptr=0 and all pending bits to 0.
- CLEAR: each non-reset edge writes 0 to reg[clr_ptr] and increments clr_ptr. The edge that clears entry NREGS-1 moves to READY. wr_en and alloc_en are ignored. busy=1.
- READY: busy=0. Write occurs when wr_en=1 and wr_addr!=0. The same edge clears pending[wr_addr].
- alloc_en=1 with alloc_addr!=0 sets pending[alloc_addr]. If alloc and write target the same address on the same edge, allocation wins and pending stays 1.
- Register 0 always reads 0. Writes to 0 are dropped and pending[0] is never set.
- Read data for port i:
  - 0 when rst=1 or busy=1.
  - Otherwise reg[rd_addr_i].
- rd_pending[i]:
  - 0 when rst=1 or busy=1.
  - Otherwise pending[rd_addr_i].
- Multiple read ports may address the same register and return identical data.

## Timing
- Read latency 0 (combinational from rd_addr).
- Write latency 1: the value is visible to reads after the write edge.
- Clear takes exactly NREGS non-reset edges after rst deasserts. busy falls after the NREGS-th edge.
- Reset asserted mid-clear restarts the sequence at entry 0.
- Reset asserted in READY aborts all pending bits on that edge. Register contents are re-cleared by the sequence.
- After reset and before the first edge, busy=1 and all outputs are 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In READY with wr_en=1, wr_addr!=0 and rd_addr_i==wr_addr, rd_data for port i returns wr_data in the same cycle.
  - rd_pending[i] for that port is forced to 0, unless alloc_en also targets the same address.
- Not defined:
  - The same read returns the old stored value until the write edge.
  - rd_pending reflects the registered pending bit.

## Test plan
- Clear sequence: assert rst 1 cycle with NREGS=32 -> busy=1 for exactly 32 edges. Every register then reads 0, and rd_pending is all 0.
- Write/read: write 0xDEADBEEF to reg 7 -> next cycle, ports 0 and 1 both addressing 7 return 0xDEADBEEF. A write of 0x5 to reg 0 is dropped, and reg 0 still reads 0.
- Scoreboard:
  - alloc reg 3 -> rd_pending=1 on the port reading 3.
  - Write reg 3 -> pending 0 after the write edge.
  - Simultaneous alloc and write to reg 3 -> pending remains 1.
- Bypass, built with REGFILE_BYPASS_EN: write 0x1234 to reg 9 while reading 9 -> rd_data=0x1234 in the same cycle. Without the macro -> old value, then 0x1234 next cycle.
- Reset mid-clear: assert rst at clear edge 10 -> clr_ptr restarts at 0, and busy stays high for 32 further edges. A wr_en pulse during busy has no effect.
- Parameters: NRD=4, NREGS=16, DATA_W=16 -> 16-edge clear, and four independent reads of distinct registers return correct values.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired zero register, pending-write scoreboard
// and post-reset clear sequencer. Define REGFILE_BYPASS_EN to forward write-back data to same-cycle reads.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr_i,
    output logic [NRD*DATA_W-1:0] rd_data_o,
    output logic [NRD-1:0]        rd_pending_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  alloc_en_i,
    input  logic [ADDR_W-1:0]     alloc_addr_i,
    output logic                  busy_o
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [NREGS-1:0]    pending_q, pending_d;
    logic [DATA_W-1:0]   mem_q [NREGS];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                wr_ok;
    logic                alloc_ok;

    assign wr_ok    = wr_en_i && (wr_addr_i != '0);
    assign alloc_ok = alloc_en_i && (alloc_addr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            pending_q <= pending_d;
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        pending_d = pending_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr_i;
        mem_wdata = wr_data_i;
        busy_o    = (state_q == CLEAR);
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                mem_we = wr_ok;
                if (wr_ok) begin
                    pending_d[wr_addr_i] = 1'b0;
                end
                // Allocation is applied last so it wins over a same-edge write-back.
                if (alloc_ok) begin
                    pending_d[alloc_addr_i] = 1'b1;
                end
            end
        endcase
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign ra = rd_addr_i[g*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            pend = 1'b0;
            if (!rst && (state_q == READY) && (ra != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (wr_addr_i == ra)) begin
                    data = wr_data_i;
                    pend = alloc_ok && (alloc_addr_i == ra);
                end else begin
                    data = mem_q[ra];
                    pend = pending_q[ra];
                end
`else
                data = mem_q[ra];
                pend = pending_q[ra];
`endif
            end
        end

        assign rd_data_o[g*DATA_W +: DATA_W] = data;
        assign rd_pending_o[g]               = pend;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a default 32x32/2-port instance checked every cycle
// against an array model, plus a 16x16/4-port instance checked with directed literals.
module tb_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        alloc_en = 1'b0;
    logic [4:0]  alloc_addr = '0;
    logic        busy;

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_pending_o(rd_pend),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_o(busy)
    );

    // Four-port, 16-entry, 16-bit instance
    logic        rst4 = 1'b1;
    logic [15:0] rd_addr4 = '0;
    logic [63:0] rd_data4;
    logic [3:0]  pend4;
    logic        wr_en4 = 1'b0;
    logic [3:0]  wr_addr4 = '0;
    logic [15:0] wr_data4 = '0;
    logic        alloc_en4 = 1'b0;
    logic [3:0]  alloc_addr4 = '0;
    logic        busy4;

    regfile_mp #(.DATA_W(16), .NREGS(16), .ADDR_W(4), .NRD(4)) dut4 (
        .clk(clk), .rst(rst4),
        .rd_addr_i(rd_addr4), .rd_data_o(rd_data4), .rd_pending_o(pend4),
        .wr_en_i(wr_en4), .wr_addr_i(wr_addr4), .wr_data_i(wr_data4),
        .alloc_en_i(alloc_en4), .alloc_addr_i(alloc_addr4), .busy_o(busy4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        else n_pass++;
    endtask

    // Model: register values, pending flags, edges left in the clear phase
    logic [31:0] m_reg [32];
    bit          m_pend [32];
    int          m_clr = 0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            m_clr   = 32;
            for (int k = 0; k < 32; k++) begin
                m_reg[k]  = '0;
                m_pend[k] = 1'b0;
            end
        end else if (m_clr > 0) begin
            m_clr = m_clr - 1;
        end else if (started) begin
            if (wr_en && wr_addr != 0) begin
                m_reg[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", busy, m_clr > 0);
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  a;
                logic [31:0] ed;
                logic        ep;
                a  = rd_addr[p*5 +: 5];
                ed = '0;
                ep = 1'b0;
                if (!rst && m_clr == 0 && a != 0) begin
                    ed = m_reg[a];
                    ep = m_pend[a];
`ifdef REGFILE_BYPASS_EN
                    if (wr_en && wr_addr == a) begin
                        ed = wr_data;
                        ep = alloc_en && alloc_addr == a;
                    end
`endif
                end
                chk($sformatf("rd_data[%0d]", p), rd_data[p*32 +: 32], ed);
                chk($sformatf("rd_pend[%0d]", p), rd_pend[p], ep);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        chk({name, "_busy_start"}, busy, 1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA_0005;
        alloc_en = 1'b1; alloc_addr = 5'd5;
        while (busy && n < 40) begin
            step();
            wr_en = 1'b0; alloc_en = 1'b0;
            n++;
        end
        chk({name, "_edges"}, n, 32);
    endtask

    initial begin
        // Clear sequence after a one-cycle reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_clear("clear1");
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            step();
        end
        rd_addr = {5'd5, 5'd5};
        #1 chk("wr_during_busy_dropped", rd_data[31:0], 32'h0);
        chk("alloc_during_busy_dropped", rd_pend[0], 1'b0);

        // Write/read on both ports
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd7, 5'd7};
        step();
        wr_en = 1'b0;
        chk("r7_port0", rd_data[31:0], 32'hDEADBEEF);
        chk("r7_port1", rd_data[63:32], 32'hDEADBEEF);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5;
        rd_addr = {5'd7, 5'd0};
        step();
        wr_en = 1'b0;
        chk("r0_zero", rd_data[31:0], 32'h0);

        // Scoreboard
        rd_addr = {5'd3, 5'd7};
        alloc_en = 1'b1; alloc_addr = 5'd3;
        step();
        alloc_en = 1'b0;
        chk("alloc3_pend", rd_pend[1], 1'b1);
        chk("r7_not_pend", rd_pend[0], 1'b0);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        step();
        wr_en = 1'b0;
        chk("wr3_clears_pend", rd_pend[1], 1'b0);
        chk("r3_value", rd_data[63:32], 32'h33);
        alloc_en = 1'b1; alloc_addr = 5'd3;
        step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
        step();
        wr_en = 1'b0; alloc_en = 1'b0;
        chk("alloc_wins_pend", rd_pend[1], 1'b1);

        // Same-cycle read of a register being written
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        step();
        rd_addr = {5'd3, 5'd9};
        wr_addr = 5'd9; wr_data = 32'h1234;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("r9_same_cycle", rd_data[31:0], 32'h1234);
`else
        chk("r9_same_cycle", rd_data[31:0], 32'h55);
`endif
        step();
        wr_en = 1'b0;
        chk("r9_next_cycle", rd_data[31:0], 32'h1234);

        // Mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 40; i++) begin
            wr_en      = (i % 3) != 0;
            wr_addr    = 5'((i * 7) % 32);
            wr_data    = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_5A5A;
            alloc_en   = (i % 4) == 1;
            alloc_addr = 5'((i * 5 + 3) % 32);
            rd_addr    = {5'((i * 11) % 32), 5'((i * 7) % 32)};
            step();
        end
        wr_en = 1'b0; alloc_en = 1'b0;

        // Reset from READY with pending bits, then reset mid-clear
        alloc_en = 1'b1; alloc_addr = 5'd20;
        step();
        alloc_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_clear("clear2");
        rd_addr = {5'd20, 5'd7};
        #1 chk("r7_cleared", rd_data[31:0], 32'h0);
        chk("r20_pend_aborted", rd_pend[1], 1'b0);
        rd_addr = {5'd3, 5'd9};
        #1 chk("r9_cleared", rd_data[31:0], 32'h0);
        chk("r3_pend_aborted", rd_pend[1], 1'b0);

        // Four-port, 16-entry instance
        rst4 = 1'b1;
        step();
        rst4 = 1'b0;
        begin
            int n;
            n = 0;
            while (busy4 && n < 40) begin
                step();
                n++;
            end
            chk("dut4_clear_edges", n, 16);
        end
        wr_en4 = 1'b1;
        wr_addr4 = 4'd2;  wr_data4 = 16'h1111; step();
        wr_addr4 = 4'd5;  wr_data4 = 16'h2222; step();
        wr_addr4 = 4'd11; wr_data4 = 16'h3333; step();
        wr_addr4 = 4'd15; wr_data4 = 16'h4444;
        alloc_en4 = 1'b1; alloc_addr4 = 4'd11; step();
        wr_en4 = 1'b0; alloc_en4 = 1'b0;
        rd_addr4 = {4'd15, 4'd11, 4'd5, 4'd2};
        @(negedge clk);
        chk("dut4_four_reads", rd_data4, 64'h4444_3333_2222_1111);
        chk("dut4_pend", pend4, 4'b0100);
        rd_addr4 = {4'd0, 4'd5, 4'd5, 4'd1};
        @(negedge clk);
        chk("dut4_shared_reads", rd_data4, 64'h0000_2222_2222_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
